// File: rtl/phase_sequencer.sv
// Fixed-time phase sequencer for a signal controller: a prescaler produces timing ticks, each
// phase dwells a parameterised number of ticks, and a latched pedestrian request may cut the
// main (phase 0) dwell short. Phase 3 is the phase that serves the pedestrian request.
module phase_sequencer #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned DWELL0   = 30,
  parameter int unsigned DWELL1   = 3,
  parameter int unsigned DWELL2   = 2,
  parameter int unsigned DWELL3   = 30,
  parameter int unsigned DWELL4   = 3,
  parameter int unsigned DWELL5   = 2,
  parameter int unsigned DWELL6   = 5,
  parameter int unsigned PED_CUT  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ped_req,
  output logic [2:0] phase,
  output logic       tick,
  output logic       wrap,
  output logic [7:0] remain,
  output logic       ped_pend
);

  localparam int unsigned PcntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PcntW-1:0] PcntMax = PcntW'(TICK_DIV - 1);
  localparam logic [7:0] PedCut   = 8'(PED_CUT);
  localparam logic [7:0] PedCutM1 = 8'(PED_CUT - 1);

  logic [PcntW-1:0] pcnt_q, pcnt_d;
  logic [2:0]       phase_q, phase_d;
  logic [7:0]       remain_q, remain_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             ped_pend_q, ped_pend_d;
  logic             tick_evt;

  // Dwell of a phase minus one, i.e. the value remain loads on phase entry.
  function automatic logic [7:0] dwell_m1(input logic [2:0] p);
    case (p)
      3'd1:    return 8'(DWELL1 - 1);
      3'd2:    return 8'(DWELL2 - 1);
      3'd3:    return 8'(DWELL3 - 1);
      3'd4:    return 8'(DWELL4 - 1);
      3'd5:    return 8'(DWELL5 - 1);
      3'd6:    return 8'(DWELL6 - 1);
      default: return 8'(DWELL0 - 1);
    endcase
  endfunction

  assign tick_evt = en && (pcnt_q == PcntMax);

  // Next-state: prescaler, phase/dwell countdown, pedestrian latch.
  always_comb begin
    pcnt_d     = pcnt_q;
    phase_d    = phase_q;
    remain_d   = remain_q;
    tick_d     = tick_evt;
    wrap_d     = 1'b0;
    ped_pend_d = ped_pend_q | ped_req;

    if (en) begin
      pcnt_d = tick_evt ? '0 : pcnt_q + 1'b1;
    end

    if (phase_q == 3'd7) begin
      // Unreachable encoding (upset): restart the cycle cleanly.
      phase_d  = 3'd0;
      remain_d = dwell_m1(3'd0);
    end else if (tick_evt) begin
      if (remain_q == 8'd0) begin
        if (phase_q == 3'd6) begin
          phase_d = 3'd0;
          wrap_d  = 1'b1;
        end else begin
          phase_d = phase_q + 3'd1;
        end
        remain_d = dwell_m1(phase_d);
      end else if (phase_q == 3'd0 && ped_pend_q && remain_q > PedCut) begin
        remain_d = PedCutM1;
      end else begin
        remain_d = remain_q - 8'd1;
      end
    end

    // Entering phase 3 serves the request, even one still asserted this cycle.
    if (phase_d == 3'd3 && phase_q != 3'd3) begin
      ped_pend_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt_q     <= '0;
      phase_q    <= 3'd0;
      remain_q   <= dwell_m1(3'd0);
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      ped_pend_q <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_d;
      phase_q    <= phase_d;
      remain_q   <= remain_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  assign phase    = phase_q;
  assign tick     = tick_q;
  assign wrap     = wrap_q;
  assign remain   = remain_q;
  assign ped_pend = ped_pend_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer with TICK_DIV=4, DWELL=3,1,1,3,1,1,2, PED_CUT=1.
// Expected per-tick state is queued ahead of time and compared as each tick appears.
module tb_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] phase;
  logic       tick;
  logic       wrap;
  logic [7:0] remain;
  logic       ped_pend;

  typedef struct {
    logic [2:0] ph;
    logic [7:0] rem;
    logic       wr;
    logic       pp;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ecnt = 0;

  phase_sequencer #(
    .TICK_DIV(4),
    .DWELL0  (3),
    .DWELL1  (1),
    .DWELL2  (1),
    .DWELL3  (3),
    .DWELL4  (1),
    .DWELL5  (1),
    .DWELL6  (2),
    .PED_CUT (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .ped_req (ped_req),
    .phase   (phase),
    .tick    (tick),
    .wrap    (wrap),
    .remain  (remain),
    .ped_pend(ped_pend)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ph, input int rem, input bit wr, input bit pp);
    exp_t e;
    e.ph  = 3'(ph);
    e.rem = 8'(rem);
    e.wr  = wr;
    e.pp  = pp;
    exp_q.push_back(e);
  endtask

  // Run n enabled cycles; tick expected every 4th enabled cycle since reset.
  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      step();
      ecnt++;
      chk("tick", 32'(tick), 32'((ecnt % 4) == 0));
      if ((ecnt % 4) == 0) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("tick_phase", 32'(phase), 32'(e.ph));
          chk("tick_remain", 32'(remain), 32'(e.rem));
          chk("tick_wrap", 32'(wrap), 32'(e.wr));
          chk("tick_ped_pend", 32'(ped_pend), 32'(e.pp));
        end
      end else begin
        chk("wrap_idle", 32'(wrap), 32'd0);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_remain", 32'(remain), 32'd2);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_ped_pend", 32'(ped_pend), 32'd0);
    chk("rst_pcnt", 32'(dut.pcnt_q), 32'd0);
    rst  = 1'b1;
    ecnt = 0;
  endtask

  initial begin
    // Free-running cycle: 12 ticks, wrap on the 12th only.
    do_reset();
    en = 1'b1;
    push(0, 1, 0, 0); push(0, 0, 0, 0); push(1, 0, 0, 0); push(2, 0, 0, 0);
    push(3, 2, 0, 0); push(3, 1, 0, 0); push(3, 0, 0, 0); push(4, 0, 0, 0);
    push(5, 0, 0, 0); push(6, 1, 0, 0); push(6, 0, 0, 0); push(0, 2, 1, 0);
    run(48);
    chk("cycle_queue_drained", 32'(exp_q.size()), 32'd0);

    // One-cycle request at cycle 2 shortens phase 0, served on phase 3 entry.
    do_reset();
    en = 1'b1;
    push(0, 0, 0, 1); push(1, 0, 0, 1); push(2, 0, 0, 1); push(3, 2, 0, 0);
    run(1);
    ped_req = 1'b1;
    run(1);
    ped_req = 1'b0;
    chk("pulse_latched", 32'(ped_pend), 32'd1);
    run(14);

    // Request held through phase-3 entry: cleared on entry, re-latched next cycle.
    do_reset();
    en = 1'b1;
    ped_req = 1'b1;
    push(0, 0, 0, 1); push(1, 0, 0, 1); push(2, 0, 0, 1); push(3, 2, 0, 0);
    run(16);
    run(1);
    chk("held_relatch", 32'(ped_pend), 32'd1);
    ped_req = 1'b0;
    run(1);

    // Freeze mid phase 3 with pcnt=2, then resume; phase 3 is not shortened.
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("frz_tick", 32'(tick), 32'd0);
      chk("frz_phase", 32'(phase), 32'd3);
      chk("frz_remain", 32'(remain), 32'd2);
      chk("frz_pcnt", 32'(dut.pcnt_q), 32'd2);
    end
    en = 1'b1;
    push(3, 1, 0, 1); push(3, 0, 0, 1); push(4, 0, 0, 1); push(5, 0, 0, 1);
    run(14);
    run(2);
    chk("pre_rst_phase", 32'(phase), 32'd5);
    chk("pre_rst_pcnt", 32'(dut.pcnt_q), 32'd2);

    // Reset mid phase 5 with en still high, then a clean restart.
    do_reset();
    push(0, 1, 0, 0);
    run(4);

    // Request with remain <= PED_CUT in phase 0: ordinary decrement.
    ped_req = 1'b1;
    run(1);
    ped_req = 1'b0;
    push(0, 0, 0, 1);
    run(3);

    // Illegal phase encoding recovers on the next edge.
    en = 1'b0;
    @(negedge clk);
    force dut.phase_q = 3'd7;
    #1;
    release dut.phase_q;
    step();
    chk("seu_phase", 32'(phase), 32'd0);
    chk("seu_remain", 32'(remain), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
